// File: rtl/mem_stage.sv
// Memory-access stage: turns an ALU result into a data-memory load/store or a
// pass-through writeback, with lane alignment, load extension and a bus timeout.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [63:0] alu_res_i,
  input  logic [63:0] store_data_i,
  input  logic [1:0]  mem_op_i,
  input  logic [1:0]  mem_size_i,
  input  logic        zext_i,
  input  logic [4:0]  rd_i,
  input  logic        wb_en_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  output logic [7:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [63:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [63:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_en_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       off_q;
  logic [1:0]       size_q;
  logic             zext_q;
  logic             wb_en_q;
  logic [63:0]      addr_q;

  logic [2:0]  off_c;
  logic        is_mem_c;
  logic        misaligned_c;
  logic [7:0]  be_c;
  logic [63:0] wdata_c;
  logic [63:0] lane_c;
  logic [63:0] load_ext_c;
  logic        timeout_c;

  // Decode the incoming op: lane offset, byte enables, alignment, shifted store data.
  always_comb begin
    off_c        = alu_res_i[2:0];
    is_mem_c     = (mem_op_i == OP_LOAD) || (mem_op_i == OP_STORE);
    misaligned_c = 1'b0;
    be_c         = 8'hFF;
    case (mem_size_i)
      SZ_B: be_c = 8'h01 << off_c;
      SZ_H: begin
        misaligned_c = off_c[0];
        be_c         = 8'h03 << off_c;
      end
      SZ_W: begin
        misaligned_c = |off_c[1:0];
        be_c         = 8'h0F << off_c;
      end
      default: begin
        misaligned_c = |off_c;
        be_c         = 8'hFF;
      end
    endcase
    wdata_c = store_data_i << {off_c, 3'b000};
  end

  // Select the addressed lane of the returned word and sign/zero-extend it.
  always_comb begin
    lane_c     = dmem_rdata_i >> {off_q, 3'b000};
    load_ext_c = lane_c;
    case (size_q)
      SZ_B: load_ext_c = zext_q ? {56'd0, lane_c[7:0]}
                                : {{56{lane_c[7]}}, lane_c[7:0]};
      SZ_H: load_ext_c = zext_q ? {48'd0, lane_c[15:0]}
                                : {{48{lane_c[15]}}, lane_c[15:0]};
      SZ_W: load_ext_c = zext_q ? {32'd0, lane_c[31:0]}
                                : {{32{lane_c[31]}}, lane_c[31:0]};
      default: load_ext_c = lane_c;
    endcase
  end

  // Expiry is checked against the cycles already spent; >= also covers a grant
  // that lands on the expiry cycle and leaves WAIT with the budget used up.
  assign timeout_c = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

  // Stage FSM with registered memory request and writeback beat.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      zext_q       <= 1'b0;
      wb_en_q      <= 1'b0;
      addr_q       <= '0;
      ready_o      <= 1'b1;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= '0;
      wb_valid_o   <= 1'b0;
      wb_data_o    <= '0;
      wb_rd_o      <= '0;
      wb_en_o      <= 1'b0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      wb_valid_o   <= 1'b0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_i && ready_o) begin
            wb_rd_o <= rd_i;
            if (!is_mem_c) begin
              wb_valid_o <= 1'b1;
              wb_data_o  <= alu_res_i;
              wb_en_o    <= wb_en_i;
            end else if (misaligned_c) begin
              wb_valid_o   <= 1'b1;
              misaligned_o <= 1'b1;
              wb_data_o    <= alu_res_i;
              wb_en_o      <= 1'b0;
            end else begin
              state_q      <= S_REQ;
              ready_o      <= 1'b0;
              cnt_q        <= '0;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= (mem_op_i == OP_STORE);
              dmem_addr_o  <= {alu_res_i[63:3], 3'b000};
              dmem_be_o    <= be_c;
              dmem_wdata_o <= wdata_c;
              off_q        <= off_c;
              size_q       <= mem_size_i;
              zext_q       <= zext_i;
              wb_en_q      <= wb_en_i;
              addr_q       <= alu_res_i;
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            if (dmem_we_o) begin
              state_q    <= S_IDLE;
              ready_o    <= 1'b1;
              wb_valid_o <= 1'b1;
              wb_data_o  <= addr_q;
              wb_en_o    <= 1'b0;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (timeout_c) begin
            dmem_req_o <= 1'b0;
            state_q    <= S_IDLE;
            ready_o    <= 1'b1;
            wb_valid_o <= 1'b1;
            bus_err_o  <= 1'b1;
            wb_data_o  <= addr_q;
            wb_en_o    <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (dmem_rvalid_i) begin
            state_q    <= S_IDLE;
            ready_o    <= 1'b1;
            wb_valid_o <= 1'b1;
            wb_data_o  <= load_ext_c;
            wb_en_o    <= wb_en_q;
          end else if (timeout_c) begin
            state_q    <= S_IDLE;
            ready_o    <= 1'b1;
            wb_valid_o <= 1'b1;
            bus_err_o  <= 1'b1;
            wb_data_o  <= addr_q;
            wb_en_o    <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          ready_o    <= 1'b1;
          dmem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
